// File: rtl/prm_edge_sweep.sv
// rtl/prm_edge_sweep.sv - PRM edge sweep sequencer: interpolates an edge and collects checker hits
module prm_edge_sweep #(
    parameter int LOG2_STEPS = 3,
    parameter int NCHK       = 8,
    parameter int ID_W       = 10,
    parameter int EARLY_EXIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ID_W-1:0]       req_id,
    input  logic [14:0]           req_start,
    input  logic [14:0]           req_end,
    output logic [14:0]           chk_vec,
    output logic                  chk_valid,
    input  logic [NCHK-1:0]       chk_mask,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_blocked,
    output logic [LOG2_STEPS:0]   res_hit_idx,
    output logic                  busy
);

    localparam int ACC_W = LOG2_STEPS + 7;
    localparam int K_W   = LOG2_STEPS + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(1 << LOG2_STEPS);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (LOG2_STEPS - 1));

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    state_t                   state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic                     hit_q, hit_d;
    logic [K_W-1:0]           hit_idx_q, hit_idx_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic signed [ACC_W-1:0]  acc_q [3];
    logic signed [ACC_W-1:0]  acc_d [3];
    logic signed [5:0]        inc_q [3];
    logic signed [5:0]        inc_d [3];
    logic [14:0]              chk_vec_q, chk_vec_d;
    logic                     mask_any;

    // Round-to-nearest of the fixed-point accumulator back to a 5-bit joint code;
    // the accumulator never leaves [start,end]*2^LOG2_STEPS so the slice cannot overflow.
    function automatic logic [4:0] samp_of(input logic signed [ACC_W-1:0] acc);
        logic [ACC_W-1:0] t;
        t = acc + HALF;
        return t[LOG2_STEPS +: 5];
    endfunction

    assign req_ready   = (state_q == ST_IDLE) && !rst;
    assign chk_valid   = (state_q == ST_SWEEP);
    assign res_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign chk_vec     = chk_vec_q;
    assign res_id      = id_q;
    assign res_blocked = hit_q;
    assign res_hit_idx = hit_idx_q;
    assign mask_any    = |chk_mask;

    // Next-state, sweep stepping, hit capture and next sample to drive
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        id_d      = id_q;
        for (int j = 0; j < 3; j++) begin
            acc_d[j] = acc_q[j];
            inc_d[j] = inc_q[j];
        end
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    id_d      = req_id;
                    k_d       = '0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    for (int j = 0; j < 3; j++) begin
                        acc_d[j] = {{(ACC_W-5){1'b0}}, req_start[5*j +: 5]} << LOG2_STEPS;
                        inc_d[j] = {1'b0, req_end[5*j +: 5]} - {1'b0, req_start[5*j +: 5]};
                    end
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (mask_any && !hit_q) begin
                    hit_d     = 1'b1;
                    hit_idx_d = k_q;
                end
                if (mask_any && (EARLY_EXIT != 0)) begin
                    state_d = ST_DONE;
                end else if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                    for (int j = 0; j < 3; j++) begin
                        acc_d[j] = acc_q[j] + {{(ACC_W-6){inc_q[j][5]}}, inc_q[j]};
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The driven sample always tracks the accumulator, so it holds while idle/done
        chk_vec_d = '0;
        for (int j = 0; j < 3; j++) begin
            chk_vec_d[5*j +: 5] = samp_of(acc_d[j]);
        end
    end

    // State and datapath registers; reset discards any edge in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            id_q      <= '0;
            chk_vec_q <= '0;
            for (int j = 0; j < 3; j++) begin
                acc_q[j] <= '0;
                inc_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            id_q      <= id_d;
            chk_vec_q <= chk_vec_d;
            for (int j = 0; j < 3; j++) begin
                acc_q[j] <= acc_d[j];
                inc_q[j] <= inc_d[j];
            end
        end
    end

endmodule

// File: doc/prm_edge_sweep.md
Name: prm_edge_sweep

Overview:
- Front-end sequencer for the PRM edge-validity checker array.
- Accepts one roadmap edge (start and end configuration, 3 joints x 5-bit quantized codes) and walks a fixed number of interpolated samples along it.
- Drives each sample onto the 15-bit check vector feeding the combinational obstacle-logic checkers, ORs their edge_mask outputs, and returns a per-edge blocked/free verdict with the first colliding sample index.

Parameters:
- LOG2_STEPS, 3, log2 of interpolation steps; samples per edge = 2^LOG2_STEPS + 1, endpoints included.
- NCHK, 8, number of checker instances whose edge_mask bits feed chk_mask.
- ID_W, 10, edge identifier width.
- EARLY_EXIT, 1, when 1 the sweep terminates on the first hit; when 0 all samples are always issued.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  edge request valid.
- req_ready  out  1  block can accept a request.
- req_id  in  ID_W  edge identifier.
- req_start  in  15  start config: joint0=[4:0], joint1=[9:5], joint2=[14:10], unsigned.
- req_end  in  15  end config, same packing.
- chk_vec  out  15  current sample to checkers, bit0..bit14 = checker inputs A..O.
- chk_valid  out  1  chk_vec holds a live sample.
- chk_mask  in  NCHK  edge_mask outputs of the checkers, combinational from chk_vec.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_id  out  ID_W  identifier of the finished edge.
- res_blocked  out  1  1 = at least one sample collided.
- res_hit_idx  out  LOG2_STEPS+1  index of first colliding sample; 0 when not blocked.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=0 while rst is high, 1 afterwards. chk_vec=0, chk_valid=0, res_valid=0, res_id=0, res_blocked=0, res_hit_idx=0, busy=0. Reset mid-sweep or mid-result discards the edge; no result is emitted.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - req_ready=1.
  - Handshake on req_valid && req_ready at a clock edge: latch req_id and start; per joint j, acc_j = start_j << LOG2_STEPS and inc_j = end_j - start_j (signed 6-bit). Set k=0, hit=0 and go to SWEEP.
  - req_ready is 0 in every other state; no request queueing.
- Sample value: per joint, samp_j = (acc_j + 2^(LOG2_STEPS-1)) >> LOG2_STEPS.
  - acc_j is signed, LOG2_STEPS+7 bits wide.
  - samp_j always lies in [min(start_j,end_j), max(start_j,end_j)], so no overflow and no saturation is needed.
  - Sample k=2^LOG2_STEPS equals end exactly.
- SWEEP:
  - chk_valid=1; chk_vec is registered, one sample per cycle.
  - Each edge, evaluate m = |chk_mask:
    - if m=1 and hit=0, record res_hit_idx=k and set hit=1;
    - if m=1 and EARLY_EXIT=1, go to DONE;
    - else if k = 2^LOG2_STEPS, go to DONE;
    - else k++ and acc_j += inc_j.
- DONE:
  - chk_valid=0; res_valid=1; res_blocked=hit; outputs held stable until res_ready.
  - On res_valid && res_ready, go to IDLE; req_ready rises the next cycle (no same-cycle result/request overlap).
- Latency from the accept edge to res_valid: hit-free edge, 2^LOG2_STEPS+1 cycles; early exit at sample k, k+1 cycles.
- start==end: all samples identical and the full sweep still runs (no shortcut).
- chk_mask is ignored whenever chk_valid=0.
- res_ready held high in DONE retires the result in one cycle. res_ready asserted outside DONE is ignored.

Test Plan:
1. Reset then sweep, LOG2_STEPS=3, joint0 0->16, others 0, chk_mask=0. Required: chk_vec[4:0] = 0,2,4,...,16 on 9 consecutive cycles; res_valid 9 cycles after accept; res_blocked=0; res_hit_idx=0.
2. Rounding check, joint1 5->2. Required: chk_vec[9:5] sequence = 5,5,4,4,4,3,3,2,2.
3. Early exit, EARLY_EXIT=1, chk_mask[3] forced high when chk_vec==0x0006 (joint0 path 0->16, k=3). Required: res_blocked=1, res_hit_idx=3, res_valid 4 cycles after accept, no further chk_valid.
4. Same stimulus as 3 with EARLY_EXIT=0. Required: 9 samples issued; res_blocked=1; res_hit_idx=3; a second hit at k=6 does not change res_hit_idx.
5. Backpressure: res_ready low for 5 cycles in DONE. Required: res_* held stable and req_ready=0 throughout; res_ready high, then req_ready=1 on the next cycle; a back-to-back request is accepted there.
6. Assert rst at k=4 of a sweep. Required: all outputs zero immediately (async); no res_valid after release; next request sweeps correctly from k=0.
